fifo_param_ctrl: RTL and testbench
==================================

// Module: fifo_param_ctrl
// PURPOSE
//  Parametrised synchronous FIFO: storage, read/write pointers, occupancy counter, 6-state
//  status FSM and registered flag/handshake outputs in one block.
//  Successor to the fixed depth-8 FIFO output logic. Adds generic width/depth, simultaneous
//  read+write, almost-full/almost-empty thresholds and a flush input.
//  Sits between a producer (wr_en/wr_data) and a consumer (rd_en/rd_data) in the datapath.
// PARAMETERS
//  DATA_W    32  data word width in bits
//  ADDR_W    3   address width; DEPTH = 2**ADDR_W entries (default 8)
//  AF_LEVEL  6   almost_full asserted when data_count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2   almost_empty asserted when data_count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1         clock; all state changes on the rising edge
//  reset         in   1         asynchronous, active-high reset
//  flush         in   1         synchronous clear of pointers/count; storage contents untouched
//  wr_en         in   1         write request
//  wr_data       in   DATA_W    write data, sampled on the clk edge with wr_en
//  rd_en         in   1         read request
//  rd_data       out  DATA_W    read data, registered
//  data_count    out  ADDR_W+1  occupancy, 0..DEPTH
//  state         out  3         FSM state (encoding below)
//  full          out  1         data_count == DEPTH
//  empty         out  1         data_count == 0
//  almost_full   out  1         data_count >= AF_LEVEL
//  almost_empty  out  1         data_count <= AE_LEVEL
//  wr_ack        out  1         previous-cycle write was accepted
//  wr_err        out  1         previous-cycle write was rejected (FIFO was full)
//  rd_ack        out  1         previous-cycle read was accepted; rd_data is valid this cycle
//  rd_err        out  1         previous-cycle read was rejected (FIFO was empty)
// BEHAVIOUR
//  Reset (async):
//   - Pointers, data_count, rd_data and all acks/errs go to 0.
//   - empty=1, almost_empty=1, full=0, almost_full=0, state=IDLE. Memory is not cleared.
//  State encoding: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, RDWR=101.
//   - 110 and 111 are unreachable; if entered, the next edge goes to IDLE.
//  Decision each edge, using count/full/empty before the edge:
//   - no request -> IDLE.
//   - wr only, !full -> WRITE: store at wr_ptr, wr_ptr+1, count+1.
//   - wr only, full -> WR_ERROR: no change to memory, pointers or count.
//   - rd only, !empty -> READ: rd_data<=mem[rd_ptr], rd_ptr+1, count-1.
//   - rd only, empty -> RD_ERROR: rd_data holds its value.
//   - wr+rd, 0<count<DEPTH -> RDWR: both performed, count unchanged.
//   - wr+rd, full -> RDWR: read mem[rd_ptr] and write to wr_ptr (==rd_ptr slot is freed).
//     Count stays DEPTH; no wr_err.
//   - wr+rd, empty -> WRITE: write accepted; read rejected with rd_err=1 and rd_ack=0.
//     No fall-through.
//  Handshake outputs are registered and valid the cycle after the request edge, for one cycle:
//   - wr_ack/wr_err/rd_ack/rd_err reflect only that edge's outcome.
//   - Within a port, ack and err are never both 1.
//  Read latency: 1 cycle. rd_data updates only on an accepted read, otherwise it holds.
//  Flags are registered from the post-edge count: full/empty/almost_* are consistent with
//  data_count in the same cycle.
//  Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally. data_count is ADDR_W+1 bits and
//  never exceeds DEPTH or goes below 0.
//  flush (sync) has priority over wr_en/rd_en:
//   - Pointers and count go to 0; empty=1; state=IDLE; all acks/errs go to 0.
//   - rd_data holds its value.
//  Reset asserted mid-operation aborts any request immediately. The first edge after
//  deassertion behaves as from IDLE/empty.
// TESTING
//  Reset: assert reset asynchronously mid-cycle -> count=0, empty=1, almost_empty=1,
//   state=000, all acks/errs 0, with no clock edge needed.
//  Fill: 8 writes of 0x11..0x88 (DEPTH=8) -> wr_ack=1 each cycle; almost_full rises at count=6;
//   full=1 at count=8. 9th write -> wr_err=1, state=WR_ERROR, count stays 8.
//  Drain: 8 reads -> rd_data 0x11..0x88 in order, each 1 cycle after rd_en, with rd_ack=1.
//   empty=1 after the last read. 9th read -> rd_err=1, state=RD_ERROR, rd_data stays 0x88.
//  Simultaneous: at count=4, wr+rd for 10 cycles -> state=RDWR, count stays 4, data in order,
//   pointers wrap past 7. At full, wr+rd -> no wr_err, count=8.
//   At empty, wr+rd -> wr_ack=1, rd_err=1, count=1.
//  Flush: at count=5 assert flush together with wr_en -> count=0, empty=1, state=IDLE,
//   wr_ack=0. A following read returns rd_err=1.

Source files
------------

// File: rtl/fifo_param_ctrl_if.sv
// Producer/consumer-facing bus of the parametrised FIFO controller.
//   master : drives flush, write request/data and read request; observes data, count, state, flags, handshakes
//   slave  : the FIFO side of the same signals
interface fifo_param_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   data_count;
  logic [2:0]        state;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, data_count, state, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, data_count, state, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );
endinterface

// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO with occupancy counter, 6-state status FSM and
// registered flags/handshakes.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fifo_param_ctrl_if.slave -- flush, wr_en/wr_data, rd_en/rd_data,
//           data_count, state, full/empty/almost_*, wr_ack/wr_err/rd_ack/rd_err
module fifo_param_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_param_ctrl_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    RDWR     = 3'b101
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_n;
  logic [DATA_W-1:0] rd_data_q;
  logic              full_q, empty_q, af_q, ae_q;
  logic              wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic              wr_ack_n, wr_err_n, rd_ack_n, rd_err_n;
  logic              do_wr, do_rd, legal, is_full, is_empty;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // Next-state, request decode and next occupancy
  always_comb begin
    state_n  = IDLE;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    wr_ack_n = 1'b0;
    wr_err_n = 1'b0;
    rd_ack_n = 1'b0;
    rd_err_n = 1'b0;
    count_n  = count_q;
    legal    = 1'b1;

    // Unused encodings perform no operation and fall back to IDLE
    case (state_q)
      IDLE, WRITE, READ, WR_ERROR, RD_ERROR, RDWR: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase

    if (!bus.flush && legal) begin
      case ({bus.wr_en, bus.rd_en})
        2'b10: begin
          if (is_full) begin
            state_n  = WR_ERROR;
            wr_err_n = 1'b1;
          end else begin
            state_n  = WRITE;
            do_wr    = 1'b1;
            wr_ack_n = 1'b1;
          end
        end
        2'b01: begin
          if (is_empty) begin
            state_n  = RD_ERROR;
            rd_err_n = 1'b1;
          end else begin
            state_n  = READ;
            do_rd    = 1'b1;
            rd_ack_n = 1'b1;
          end
        end
        2'b11: begin
          // Empty: no fall-through, the read is rejected while the write lands
          if (is_empty) begin
            state_n  = WRITE;
            do_wr    = 1'b1;
            wr_ack_n = 1'b1;
            rd_err_n = 1'b1;
          end else begin
            // Full: the slot being read is the one being overwritten
            state_n  = RDWR;
            do_wr    = 1'b1;
            do_rd    = 1'b1;
            wr_ack_n = 1'b1;
            rd_ack_n = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (bus.flush) begin
      count_n = '0;
    end else if (do_wr && !do_rd) begin
      count_n = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_n = count_q - CW'(1);
    end
  end

  // State, pointers, count, read data, flags and handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      full_q   <= (count_n == CW'(DEPTH));
      empty_q  <= (count_n == '0);
      af_q     <= (count_n >= CW'(AF_LEVEL));
      ae_q     <= (count_n <= CW'(AE_LEVEL));
      wr_ack_q <= wr_ack_n;
      wr_err_q <= wr_err_n;
      rd_ack_q <= rd_ack_n;
      rd_err_q <= rd_err_n;
      if (do_rd) begin
        rd_data_q <= mem[rd_ptr_q];
      end
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_wr) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (do_rd) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Storage has no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.data_count   = count_q;
  assign bus.state        = state_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_err       = rd_err_q;

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Directed self-checking bench for fifo_param_ctrl (DATA_W=32, DEPTH=8, AF=6, AE=2).
module tb_fifo_param_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fifo_param_ctrl_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  fifo_param_ctrl #(
    .DATA_W(32), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {count[3:0], state[2:0], full, empty, af, ae, wr_ack, wr_err, rd_ack, rd_err}
  logic [14:0] status;
  assign status = {bus.data_count, bus.state, bus.full, bus.empty, bus.almost_full,
                   bus.almost_empty, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = 32'hA0 + 32'(i);
      tick();
    end
    exp = {4'd3, 3'b001, 4'b0000, 4'b1000};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL pre_reset_status: got %h expected %h", status, exp);
    end
    bus.wr_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    exp = {4'd0, 3'b000, 4'b0101, 4'b0000};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL async_reset_status: got %h expected %h", status, exp);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset_rd_data: got %h expected %h", bus.rd_data, 32'h0);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    logic [14:0] exp;
    int c;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 32'((i + 1) * 17);
      tick();
      c = i + 1;
      exp = {4'(c), 3'b001, (c == 8), 1'b0, (c >= 6), (c <= 2), 4'b1000};
      n_cmp++;
      if (status !== exp) begin
        n_bad++;
        $display("FAIL fill_%0d: got %h expected %h", c, status, exp);
      end
    end
    tick();
    exp = {4'd8, 3'b011, 4'b1010, 4'b0100};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL fill_overflow: got %h expected %h", status, exp);
    end
    bus.wr_en = 1'b0;
    tick();
    exp = {4'd8, 3'b000, 4'b1010, 4'b0000};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL fill_idle: got %h expected %h", status, exp);
    end
  endtask

  task automatic test_drain();
    logic [14:0] exp;
    int c;
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1;
      tick();
      c = 7 - i;
      exp = {4'(c), 3'b010, 1'b0, (c == 0), (c >= 6), (c <= 2), 4'b0010};
      n_cmp++;
      if (status !== exp) begin
        n_bad++;
        $display("FAIL drain_status_%0d: got %h expected %h", i, status, exp);
      end
      n_cmp++;
      if (bus.rd_data !== 32'((i + 1) * 17)) begin
        n_bad++;
        $display("FAIL drain_data_%0d: got %h expected %h", i, bus.rd_data, 32'((i + 1) * 17));
      end
    end
    tick();
    exp = {4'd0, 3'b100, 4'b0101, 4'b0001};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL drain_underflow: got %h expected %h", status, exp);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h88) begin
      n_bad++;
      $display("FAIL drain_underflow_hold: got %h expected %h", bus.rd_data, 32'h88);
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [14:0] exp;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 32'h101 + 32'(i);
      tick();
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_data = 32'h105 + 32'(i);
      tick();
      exp = {4'd4, 3'b101, 4'b0000, 4'b1010};
      n_cmp++;
      if (status !== exp) begin
        n_bad++;
        $display("FAIL rdwr_status_%0d: got %h expected %h", i, status, exp);
      end
      n_cmp++;
      if (bus.rd_data !== 32'h101 + 32'(i)) begin
        n_bad++;
        $display("FAIL rdwr_data_%0d: got %h expected %h", i, bus.rd_data, 32'h101 + 32'(i));
      end
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.rd_data !== 32'h10B + 32'(i)) begin
        n_bad++;
        $display("FAIL rdwr_tail_%0d: got %h expected %h", i, bus.rd_data, 32'h10B + 32'(i));
      end
    end
    bus.rd_en = 1'b0;
    tick();
    n_cmp++;
    if (status !== {4'd0, 3'b000, 4'b0101, 4'b0000}) begin
      n_bad++;
      $display("FAIL rdwr_empty_after: got %h expected %h", status, {4'd0, 3'b000, 4'b0101, 4'b0000});
    end
  endtask

  task automatic test_full_rdwr();
    logic [14:0] exp;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = 32'h201 + 32'(i);
      tick();
    end
    bus.rd_en   = 1'b1;
    bus.wr_data = 32'h209;
    tick();
    exp = {4'd8, 3'b101, 4'b1010, 4'b1010};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL full_rdwr_status: got %h expected %h", status, exp);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h201) begin
      n_bad++;
      $display("FAIL full_rdwr_data: got %h expected %h", bus.rd_data, 32'h201);
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (bus.rd_data !== 32'h202 + 32'(i)) begin
        n_bad++;
        $display("FAIL full_rdwr_drain_%0d: got %h expected %h", i, bus.rd_data, 32'h202 + 32'(i));
      end
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_empty_rdwr();
    logic [14:0] exp;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 32'h301;
    tick();
    exp = {4'd1, 3'b001, 4'b0001, 4'b1001};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL empty_rdwr_status: got %h expected %h", status, exp);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h209) begin
      n_bad++;
      $display("FAIL empty_rdwr_hold: got %h expected %h", bus.rd_data, 32'h209);
    end
    bus.wr_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.rd_data !== 32'h301) begin
      n_bad++;
      $display("FAIL empty_rdwr_followup: got %h expected %h", bus.rd_data, 32'h301);
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [14:0] exp;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 32'h401 + 32'(i);
      tick();
    end
    exp = {4'd5, 3'b001, 4'b0000, 4'b1000};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL flush_pre: got %h expected %h", status, exp);
    end
    bus.flush   = 1'b1;
    bus.wr_data = 32'h4FF;
    tick();
    exp = {4'd0, 3'b000, 4'b0101, 4'b0000};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL flush_status: got %h expected %h", status, exp);
    end
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    exp = {4'd0, 3'b100, 4'b0101, 4'b0001};
    n_cmp++;
    if (status !== exp) begin
      n_bad++;
      $display("FAIL flush_read: got %h expected %h", status, exp);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h301) begin
      n_bad++;
      $display("FAIL flush_rd_data_hold: got %h expected %h", bus.rd_data, 32'h301);
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_rdwr();
    test_empty_rdwr();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
